// File: rtl/cipher_pkg.sv
// cipher_pkg: shared widths, FSM states and byte cipher for the XOR cipher path
package cipher_pkg;
    localparam int DATA_W   = 8;
    localparam int MAX_KEYS = 8;
    localparam int KEY_AW   = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic [DATA_W-1:0] xor_byte(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] k);
        return d ^ k;
    endfunction
endpackage

// File: rtl/cipher_key_table.sv
// cipher_key_table: key register file, synchronous write, combinational read
module cipher_key_table
    import cipher_pkg::*;
(
    input  logic              Clk,
    input  logic              nReset,
    input  logic              WrEn,
    input  logic [KEY_AW-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic [KEY_AW-1:0] RdAddr,
    output logic [DATA_W-1:0] RdData
);
    logic [DATA_W-1:0] mem [MAX_KEYS];

    always_ff @(posedge Clk) begin
        if (!nReset)
            mem <= '{default: '0};
        else if (WrEn)
            mem[WrAddr] <= WrData;
    end

    assign RdData = mem[RdAddr];
endmodule

// File: rtl/stream_decryption.sv
// stream_decryption: packetised XOR decryption with rotating keys and valid/ready flow control
module stream_decryption
    import cipher_pkg::*;
(
    input  logic              Clk,
    input  logic              nReset,
    input  logic              KeyWr,
    input  logic [KEY_AW-1:0] KeyAddr,
    input  logic [DATA_W-1:0] KeyIn,
    input  logic              Start,
    input  logic [7:0]        SizeOfData,
    input  logic [KEY_AW:0]   NumberOfKeys,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              InValid,
    output logic              InReady,
    output logic [DATA_W-1:0] DataOut,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              Ready,
    output logic              Done,
    output logic              ConfigErr
);
    localparam logic [KEY_AW:0] MAX_N = (KEY_AW+1)'(MAX_KEYS);

    state_t            state, state_nxt;
    logic [7:0]        size_q, byte_cnt;
    logic [KEY_AW:0]   nkeys_q;
    logic [KEY_AW-1:0] key_idx;
    logic [DATA_W-1:0] key;
    logic              idle, n_ok, xfer, accept, last;

    cipher_key_table u_keys (
        .Clk    (Clk),
        .nReset (nReset),
        .WrEn   (KeyWr && idle),
        .WrAddr (KeyAddr),
        .WrData (KeyIn),
        .RdAddr (key_idx),
        .RdData (key)
    );

    assign idle    = state == IDLE;
    assign Ready   = idle;
    assign n_ok    = NumberOfKeys != '0 && NumberOfKeys <= MAX_N;
    assign InReady = state == RUN && (!OutValid || OutReady);
    assign xfer    = InValid && InReady;
    assign accept  = OutValid && OutReady;
    assign last    = byte_cnt == size_q - 8'd1;

    always_ff @(posedge Clk) begin
        if (!nReset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (idle && Start && n_ok && SizeOfData != 8'd0)
            state_nxt = RUN;
        if (state == RUN && xfer && last)
            state_nxt = DRAIN;
        if (state == DRAIN && accept)
            state_nxt = IDLE;
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            size_q    <= '0;
            nkeys_q   <= '0;
            key_idx   <= '0;
            byte_cnt  <= '0;
            DataOut   <= '0;
            OutValid  <= 1'b0;
            Done      <= 1'b0;
            ConfigErr <= 1'b0;
        end else begin
            Done      <= (idle && Start && n_ok && SizeOfData == 8'd0) || (state == DRAIN && accept);
            ConfigErr <= idle && Start && !n_ok;
            if (idle && Start) begin
                size_q   <= SizeOfData;
                nkeys_q  <= NumberOfKeys;
                key_idx  <= '0;
                byte_cnt <= '0;
            end
            // a new byte may replace the held one in the same cycle it is accepted
            if (xfer) begin
                DataOut  <= xor_byte(DataIn, key);
                OutValid <= 1'b1;
                key_idx  <= {1'b0, key_idx} == nkeys_q - 1'b1 ? '0 : key_idx + 1'b1;
                byte_cnt <= byte_cnt + 8'd1;
            end else if (OutReady) begin
                OutValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_decryption.sv
// tb_stream_decryption: randomized and directed checks against a packet-level XOR model
module tb_stream_decryption;
    import cipher_pkg::*;

    logic       Clk = 1'b0, nReset = 1'b0, KeyWr = 1'b0, Start = 1'b0, InValid = 1'b0, OutReady = 1'b0;
    logic [2:0] KeyAddr = '0;
    logic [7:0] KeyIn = '0, SizeOfData = '0, DataIn = '0;
    logic [3:0] NumberOfKeys = '0;
    logic       InReady, OutValid, Ready, Done, ConfigErr;
    logic [7:0] DataOut;

    int         n_checks = 0, n_fail = 0;
    logic [7:0] mkeys [8];
    logic [7:0] din [256];

    stream_decryption dut (
        .Clk(Clk), .nReset(nReset), .KeyWr(KeyWr), .KeyAddr(KeyAddr), .KeyIn(KeyIn),
        .Start(Start), .SizeOfData(SizeOfData), .NumberOfKeys(NumberOfKeys),
        .DataIn(DataIn), .InValid(InValid), .InReady(InReady),
        .DataOut(DataOut), .OutValid(OutValid), .OutReady(OutReady),
        .Ready(Ready), .Done(Done), .ConfigErr(ConfigErr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, Ready, 1);
        check({tag, "_inready"}, InReady, 0);
        check({tag, "_outvalid"}, OutValid, 0);
        check({tag, "_dataout"}, DataOut, 0);
        check({tag, "_done"}, Done, 0);
        check({tag, "_cfgerr"}, ConfigErr, 0);
    endtask

    task automatic write_key(input int a, input logic [7:0] v);
        KeyWr = 1'b1; KeyAddr = 3'(a); KeyIn = v;
        tick();
        KeyWr = 1'b0;
        mkeys[a] = v;
    endtask

    task automatic start_pkt(input int size, input int n);
        Start = 1'b1; SizeOfData = 8'(size); NumberOfKeys = 4'(n);
        tick();
        Start = 1'b0;
    endtask

    task automatic cfg_err(input int n);
        start_pkt(4, n);
        check($sformatf("cfgerr_n%0d", n), ConfigErr, 1);
        check($sformatf("cfgerr_ready_n%0d", n), Ready, 1);
        tick();
        check($sformatf("cfgerr_pulse_n%0d", n), ConfigErr, 0);
        check($sformatf("cfgerr_idle_n%0d", n), Ready, 1);
    endtask

    // expected plaintext: byte i is decrypted with key (i mod n)
    task automatic run_packet(input int size, input int n, input bit rnd, input int stall_after, input bit key_poke);
        logic [7:0] exp [$];
        logic [7:0] hv;
        int idx = 0, got = 0, cyc = 0, stall = 0;
        hv = '0;
        for (int i = 0; i < size; i++) exp.push_back(din[i] ^ mkeys[i % n]);
        start_pkt(size, n);
        check("ready_low_after_start", Ready, 0);
        while (got < size && cyc < 4000) begin
            InValid  = idx < size && (!rnd || $urandom_range(0, 3) != 0);
            DataIn   = InValid ? din[idx] : 8'($urandom);
            OutReady = stall > 0 ? 1'b0 : (!rnd || $urandom_range(0, 2) != 0);
            KeyWr    = key_poke && cyc == 1;
            KeyAddr  = '0;
            KeyIn    = 8'hFF;
            #1;
            if (stall > 0) begin
                if (stall == 3) hv = DataOut;
                check("hold_inready", InReady, 0);
                check("hold_outvalid", OutValid, 1);
                check("hold_dataout", DataOut, hv);
                stall--;
            end else begin
                check("ready_busy", Ready, 0);
            end
            if (InValid && InReady) idx++;
            if (OutValid && OutReady) begin
                check($sformatf("data%0d", got), DataOut, exp.pop_front());
                got++;
                if (got == stall_after) stall = 3;
            end
            tick();
            cyc++;
        end
        InValid = 1'b0; OutReady = 1'b1; KeyWr = 1'b0;
        check("bytes_delivered", got, size);
        check("done_pulse", Done, 1);
        check("ready_idle", Ready, 1);
        check("outvalid_clear", OutValid, 0);
        tick();
        check("done_single", Done, 0);
    endtask

    initial begin
        foreach (mkeys[i]) mkeys[i] = '0;
        tick();
        check_reset_outputs("reset");
        nReset = 1'b1;

        write_key(0, 8'h5A);
        din[0] = 8'h00; din[1] = 8'hFF; din[2] = 8'h5A; din[3] = 8'hA5;
        run_packet(4, 1, 0, 0, 0);

        write_key(0, 8'h01); write_key(1, 8'h02); write_key(2, 8'h03);
        for (int i = 0; i < 7; i++) din[i] = 8'h10;
        run_packet(7, 3, 0, 0, 0);

        for (int i = 0; i < 5; i++) din[i] = 8'($urandom);
        run_packet(5, 3, 0, 2, 0);

        cfg_err(0);
        cfg_err(9);
        start_pkt(0, 1);
        check("size0_done", Done, 1);
        check("size0_ready", Ready, 1);
        check("size0_outvalid", OutValid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("size0_no_output", OutValid, 0);
            check("size0_done_once", Done, 0);
        end

        write_key(0, 8'h77);
        for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
        run_packet(4, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) din[i] = 8'($urandom);
        run_packet(3, 1, 0, 0, 0);

        write_key(0, 8'hAB); write_key(1, 8'hCD);
        start_pkt(5, 2);
        InValid = 1'b1; OutReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            DataIn = 8'($urandom);
            tick();
        end
        InValid = 1'b0;
        nReset = 1'b0;
        tick();
        check_reset_outputs("midreset");
        nReset = 1'b1;
        foreach (mkeys[i]) mkeys[i] = '0;
        for (int i = 0; i < 8; i++) din[i] = 8'($urandom);
        run_packet(8, 8, 0, 0, 0);
        write_key(0, 8'h11);
        din[0] = 8'h11;
        run_packet(1, 1, 0, 0, 0);

        write_key(0, 8'h3C);
        din[0] = xor_byte(8'h81, 8'h3C);
        run_packet(1, 1, 0, 0, 0);

        for (int p = 0; p < 20; p++) begin
            int n, size;
            n = $urandom_range(1, 8);
            size = $urandom_range(1, 40);
            for (int k = 0; k < 8; k++) write_key(k, 8'($urandom));
            for (int i = 0; i < size; i++) din[i] = 8'($urandom);
            run_packet(size, n, 1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
